// File: rtl/sc_et_counter.sv
// sc_et_counter
// Stochastic-to-binary converter with early termination. Counts the ones of a
// unipolar bitstream over a 2^k-bit window (k = min(et_log2, WIDTH)) and stops
// early once a threshold decision can no longer change.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a conversion (sampled only in IDLE)
//   abort           cancel the run in progress, no done pulse
//   et_log2         window length exponent k (clamped to WIDTH)
//   thresh_en       enable threshold early termination
//   thresh          threshold in value units
//   bit_in          stream bit
//   bit_valid       bit_in is consumed this cycle (RUN only)
//   busy            high while in RUN
//   done            one-cycle pulse, results valid from this cycle
//   result          scaled ones count, saturated to 2^WIDTH-1
//   decision        estimate >= thresh (0 when thresh_en was 0)
//   cycles_used     bits consumed by the last completed run
module sc_et_counter #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [KW-1:0]    et_log2,
    input  logic             thresh_en,
    input  logic [WIDTH-1:0] thresh,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             decision,
    output logic [WIDTH:0]   cycles_used
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Per-run configuration and counters
    logic [KW-1:0]  k_q;
    logic           te_q;
    logic [WIDTH:0] tc_q;
    logic [WIDTH:0] cnt_q;
    logic [WIDTH:0] cyc_q;

    // Start-time configuration: clamp k and convert the threshold into ones
    // count units, rounding up so cnt >= tc matches cnt*2^s >= thresh.
    logic [KW-1:0]  k_in;
    logic [KW-1:0]  shift_in;
    logic [WIDTH:0] round_up;
    logic [WIDTH:0] tc_in;

    assign k_in     = (et_log2 > KW'(WIDTH)) ? KW'(WIDTH) : et_log2;
    assign shift_in = KW'(WIDTH) - k_in;
    assign round_up = ((WIDTH + 1)'(1) << shift_in) - (WIDTH + 1)'(1);
    assign tc_in    = ({1'b0, thresh} + round_up) >> shift_in;

    // Termination evaluated on the counters as they will be after this bit.
    // cnt_nx + left never exceeds the window, so WIDTH+1 bits suffice.
    logic [WIDTH:0] cyc_nx;
    logic [WIDTH:0] cnt_nx;
    logic [WIDTH:0] window;
    logic [WIDTH:0] left;
    logic [WIDTH:0] scaled;
    logic [KW-1:0]  shift_q;
    logic           stop_len;
    logic           stop_hi;
    logic           stop_lo;
    logic           stop;

    assign cyc_nx   = cyc_q + (WIDTH + 1)'(1);
    assign cnt_nx   = cnt_q + {{WIDTH{1'b0}}, bit_in};
    assign window   = (WIDTH + 1)'(1) << k_q;
    assign left     = window - cyc_nx;
    assign stop_len = (cyc_nx == window);
    assign stop_hi  = te_q && (cnt_nx >= tc_q);
    assign stop_lo  = te_q && ((cnt_nx + left) < tc_q);
    assign stop     = bit_valid && (stop_len || stop_hi || stop_lo);
    assign shift_q  = KW'(WIDTH) - k_q;
    // cnt <= 2^k, so the shifted value fits in WIDTH+1 bits; only the
    // all-ones window reaches bit WIDTH and needs saturating.
    assign scaled   = cnt_nx << shift_q;

    // State register
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort wins over a same-cycle termination
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch forms.
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (stop) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Configuration, counters and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            te_q        <= 1'b0;
            tc_q        <= '0;
            cnt_q       <= '0;
            cyc_q       <= '0;
            result      <= '0;
            decision    <= 1'b0;
            cycles_used <= '0;
        end else begin
            if (state == IDLE && start) begin
                k_q   <= k_in;
                te_q  <= thresh_en;
                tc_q  <= tc_in;
                cnt_q <= '0;
                cyc_q <= '0;
            end
            if (state == RUN && !abort && bit_valid) begin
                cnt_q <= cnt_nx;
                cyc_q <= cyc_nx;
                if (stop) begin
                    result      <= scaled[WIDTH] ? {WIDTH{1'b1}} : scaled[WIDTH-1:0];
                    // Covers (b), (c) and a length stop alike
                    decision    <= stop_hi;
                    cycles_used <= cyc_nx;
                end
            end
        end
    end

    // Decoded directly from the state register
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sc_et_counter.sv
// Self-checking bench for sc_et_counter: directed scenarios plus randomized
// runs checked against an arithmetic model of the conversion rules.
module tb_sc_et_counter;

    localparam int WIDTH = 8;
    localparam int KW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [KW-1:0]    et_log2 = '0;
    logic             thresh_en = 1'b0;
    logic [WIDTH-1:0] thresh = '0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             decision;
    logic [WIDTH:0]   cycles_used;

    int n_checks = 0;
    int n_pass   = 0;

    // Results the DUT must be holding (last completed run, or 0 after reset)
    int last_res = 0;
    int last_dec = 0;
    int last_cyc = 0;

    sc_et_counter #(.WIDTH(WIDTH), .KW(KW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .et_log2     (et_log2),
        .thresh_en   (thresh_en),
        .thresh      (thresh),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .decision    (decision),
        .cycles_used (cycles_used)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_result"}, 32'(result), 32'(last_res));
        check({tag, "_decision"}, 32'(decision), 32'(last_dec));
        check({tag, "_cycles"}, 32'(cycles_used), 32'(last_cyc));
    endtask

    // One conversion. mode: 0 alternating 1/0, 1 all ones, 2 all zeros,
    // 3 random. vprob: percent of cycles with bit_valid. abort_at: abort
    // together with that (1-based) bit. max_bits: leave the DUT in RUN after
    // that many bits. pulse: randomly assert start while running.
    task automatic run_conv(input int k_in, input int te, input int th, input int mode,
                            input int vprob, input int abort_at, input int max_bits,
                            input int pulse);
        int  k, d, win, tc, ones, n, exp_res;
        bit  b, v, stop;
        k   = (k_in > WIDTH) ? WIDTH : k_in;
        d   = 1 << (WIDTH - k);
        win = 1 << k;
        tc  = (th + d - 1) / d;
        @(negedge clk);
        start     = 1'b1;
        et_log2   = KW'(k_in);
        thresh_en = (te != 0);
        thresh    = WIDTH'(th);
        bit_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {busy, done}, 2'b10);
        ones = 0;
        n    = 0;
        for (int c = 0; c < 4000; c++) begin
            if (max_bits != 0 && n == max_bits) return;
            v = (vprob >= 100) || ($urandom_range(99) < vprob);
            case (mode)
                0:       b = (n % 2 == 0);
                1:       b = 1'b1;
                2:       b = 1'b0;
                default: b = 1'($urandom_range(1));
            endcase
            bit_valid = v;
            bit_in    = b;
            start     = (pulse != 0) ? 1'($urandom_range(1)) : 1'b0;
            if (abort_at != 0 && v && n == abort_at - 1) begin
                abort = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                bit_valid = 1'b0;
                start     = 1'b0;
                check("abort_idle", {busy, done}, 2'b00);
                check_held("abort");
                @(negedge clk);
                check("abort_no_done", {busy, done}, 2'b00);
                return;
            end
            @(negedge clk);
            if (v) begin
                n++;
                ones += int'(b);
            end
            stop = v && ((n == win) || (te != 0 && ones >= tc) ||
                         (te != 0 && ones + (win - n) < tc));
            bit_valid = 1'b0;
            start     = 1'b0;
            if (stop) begin
                exp_res  = ones * d;
                last_res = (exp_res > 255) ? 255 : exp_res;
                last_dec = (te != 0 && ones >= tc) ? 1 : 0;
                last_cyc = n;
                check("done_pulse", {busy, done}, 2'b01);
                check_held("done");
                @(negedge clk);
                check("back_idle", {busy, done}, 2'b00);
                check_held("idle");
                return;
            end else begin
                check("running", {busy, done}, 2'b10);
            end
        end
        check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #17;
        check("reset_outputs", {busy, done, decision}, 3'b000);
        check_held("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // k=4 alternating, continuous valid: result 128, 16 cycles
        run_conv(4, 0, 0, 0, 100, 0, 0, 0);
        check("alt_result", 32'(result), 32'd128);
        // k=8 all ones saturates
        run_conv(8, 0, 0, 1, 100, 0, 0, 0);
        check("sat_result", 32'(result), 32'd255);
        // Threshold hit after 64 ones
        run_conv(8, 1, 64, 1, 100, 0, 0, 0);
        check("hi_cycles", 32'(cycles_used), 32'd64);
        // Threshold unreachable at cyc=57
        run_conv(8, 1, 200, 2, 100, 0, 0, 0);
        check("lo_cycles", 32'(cycles_used), 32'd57);
        // thresh=0 stops on the first bit with decision 1
        run_conv(5, 1, 0, 3, 100, 0, 0, 0);
        check("th0_cycles", 32'(cycles_used), 32'd1);
        // Gapped valid, start pulsed while busy, abort with bit 5
        run_conv(4, 0, 0, 0, 50, 5, 0, 1);
        run_conv(4, 0, 0, 0, 50, 0, 0, 1);
        // Clamp of et_log2 above WIDTH
        run_conv(13, 0, 0, 0, 100, 0, 0, 0);

        // Asynchronous reset mid-run after 30 ones
        run_conv(8, 0, 0, 1, 100, 0, 30, 0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        last_res = 0;
        last_dec = 0;
        last_cyc = 0;
        check("mid_reset", {busy, done}, 2'b00);
        check_held("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(0, 0, 0, 1, 100, 0, 0, 0);
        check("k0_result", 32'(result), 32'd255);

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            run_conv($urandom_range(15), $urandom_range(1), $urandom_range(255),
                     $urandom_range(3), $urandom_range(100, 30),
                     ($urandom_range(5) == 0) ? $urandom_range(6, 1) : 0,
                     0, $urandom_range(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
